// File: rtl/sram_port_arbiter_if.sv
// Two requester ports, the single-port SRAM lines and the grant counters of sram_port_arbiter.
// The slave modport is the arbiter side; the master modport is the requesters plus the SRAM.
interface sram_port_arbiter_if #(
    parameter int ADDR  = 8,
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             req0;
    logic             we0;
    logic [ADDR-1:0]  addr0;
    logic [WIDTH-1:0] wdata0;
    logic             gnt0;
    logic             rvalid0;
    logic [WIDTH-1:0] rdata0;

    logic             req1;
    logic             we1;
    logic [ADDR-1:0]  addr1;
    logic [WIDTH-1:0] wdata1;
    logic             gnt1;
    logic             rvalid1;
    logic [WIDTH-1:0] rdata1;

    logic             mem_cs;
    logic             mem_we;
    logic [ADDR-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    logic             clr_cnt;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata, clr_cnt,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_cs, mem_we, mem_addr, mem_wdata,
        output cnt0, cnt1
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata, clr_cnt,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        input  cnt0, cnt1
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter serialising two request ports onto one registered single-port SRAM.
// Grant 1 cycle after req is sampled in IDLE, rvalid 2 cycles after grant; requesters hold req until gnt.
module sram_port_arbiter #(
    parameter int ADDR  = 8,
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             mem_cs_q, mem_cs_d;
    logic             mem_we_q, mem_we_d;
    logic [ADDR-1:0]  mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic [WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             win;
    logic             win_we;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        mem_cs_d    = mem_cs_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;

        // A tie goes to the port that was not granted last; a lone request wins outright.
        win    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
        win_we = win ? bus.we1 : bus.we0;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d     = ISSUE;
                    mem_cs_d    = 1'b1;
                    mem_we_d    = win_we;
                    mem_addr_d  = win ? bus.addr1 : bus.addr0;
                    mem_wdata_d = win_we ? (win ? bus.wdata1 : bus.wdata0) : '0;
                    gnt0_d      = ~win;
                    gnt1_d      = win;
                    owner_d     = win;
                    last_d      = win;
                    if (!win && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + 1'b1;
                    if (win && cnt1_q != CNT_MAX)  cnt1_d = cnt1_q + 1'b1;
                end
            end
            ISSUE: begin
                mem_cs_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = mem_we_q ? IDLE : WAIT;
            end
            WAIT: begin
                // The SRAM registers its output, so read data is on mem_rdata now.
                if (owner_q) begin
                    rdata1_d  = bus.mem_rdata;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = bus.mem_rdata;
                    rvalid0_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.clr_cnt) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_cs    = mem_cs_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cnt0      = cnt0_q;
    assign bus.cnt1      = cnt1_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a registered SRAM model behind it.
// Counters are built 4 bits wide here so saturation is reached in a few dozen grants.
module tb_sram_port_arbiter;
    localparam int ADDR  = 8;
    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;

    logic             bd_we;
    logic [ADDR-1:0]  bd_addr;
    logic [WIDTH-1:0] bd_dat;
    logic [WIDTH-1:0] mem [0:255];

    int vectors;
    int miscompares;

    sram_port_arbiter_if #(.ADDR(ADDR), .WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    sram_port_arbiter #(.ADDR(ADDR), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: output registered on the edge that ends the chip-select cycle.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_dat;
        if (bus.mem_cs) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.clr_cnt = 1'b0;
        bd_we       = 1'b0;
        bd_addr     = '0;
        bd_dat      = '0;
        idle_reqs();

        // Preload while held in reset.
        bd_we = 1'b1;
        bd_addr = 8'h10; bd_dat = 32'hDEADBEEF; step();
        bd_addr = 8'h30; bd_dat = 32'hA5A50030; step();
        bd_addr = 8'h31; bd_dat = 32'h5A5A0031; step();
        bd_we = 1'b0;

        chk("rst_cs",      bus.mem_cs,  0);
        chk("rst_gnt0",    bus.gnt0,    0);
        chk("rst_gnt1",    bus.gnt1,    0);
        chk("rst_rvalid0", bus.rvalid0, 0);
        chk("rst_rdata0",  bus.rdata0,  0);
        chk("rst_cnt0",    bus.cnt0,    0);
        chk("rst_cnt1",    bus.cnt1,    0);
        rst_n = 1'b1;

        // Port 0 read of 0x10.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        step();
        chk("rd0_gnt0",  bus.gnt0,     1);
        chk("rd0_gnt1",  bus.gnt1,     0);
        chk("rd0_cs",    bus.mem_cs,   1);
        chk("rd0_we",    bus.mem_we,   0);
        chk("rd0_addr",  bus.mem_addr, 32'h10);
        chk("rd0_wdata", bus.mem_wdata, 0);
        bus.req0 = 1'b0;
        step();
        chk("rd0_cs_drop",  bus.mem_cs,  0);
        chk("rd0_gnt_drop", bus.gnt0,    0);
        chk("rd0_early_rv", bus.rvalid0, 0);
        step();
        chk("rd0_rvalid", bus.rvalid0, 1);
        chk("rd0_rdata",  bus.rdata0,  32'hDEADBEEF);
        chk("rd0_rv1",    bus.rvalid1, 0);
        chk("rd0_cnt0",   bus.cnt0,    1);

        // Port 1 write of 0x20.
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h20; bus.wdata1 = 32'h12345678;
        step();
        chk("wr1_gnt1",  bus.gnt1,      1);
        chk("wr1_gnt0",  bus.gnt0,      0);
        chk("wr1_cs",    bus.mem_cs,    1);
        chk("wr1_we",    bus.mem_we,    1);
        chk("wr1_addr",  bus.mem_addr,  32'h20);
        chk("wr1_wdata", bus.mem_wdata, 32'h12345678);
        chk("rv0_pulse", bus.rvalid0,   0);
        chk("rd0_hold",  bus.rdata0,    32'hDEADBEEF);
        idle_reqs();
        step();
        chk("wr1_cs_drop", bus.mem_cs,  0);
        chk("wr1_we_drop", bus.mem_we,  0);
        chk("wr1_no_rv1",  bus.rvalid1, 0);
        // Back in IDLE: read the written word back through port 1.
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
        step();
        chk("rb1_gnt1",  bus.gnt1,    1);
        chk("rb1_no_rv", bus.rvalid1, 0);
        idle_reqs();
        step();
        step();
        chk("rb1_rvalid", bus.rvalid1, 1);
        chk("rb1_rdata",  bus.rdata1,  32'h12345678);
        chk("rb1_rv0",    bus.rvalid0, 0);
        chk("rb1_cnt1",   bus.cnt1,    2);

        bus.clr_cnt = 1'b1;
        step();
        bus.clr_cnt = 1'b0;
        chk("clr_cnt0", bus.cnt0, 0);
        chk("clr_cnt1", bus.cnt1, 0);

        // Both ports reading continuously: grants must alternate starting with port 0.
        bus.req0 = 1'b1; bus.addr0 = 8'h30;
        bus.req1 = 1'b1; bus.addr1 = 8'h31;
        for (int g = 0; g < 4; g++) begin
            logic p;
            p = logic'(g % 2);
            step();
            chk($sformatf("alt%0d_gnt0", g), bus.gnt0, p ? 0 : 1);
            chk($sformatf("alt%0d_gnt1", g), bus.gnt1, p ? 1 : 0);
            chk($sformatf("alt%0d_addr", g), bus.mem_addr, p ? 32'h31 : 32'h30);
            step();
            step();
            chk($sformatf("alt%0d_rv0", g), bus.rvalid0, p ? 0 : 1);
            chk($sformatf("alt%0d_rv1", g), bus.rvalid1, p ? 1 : 0);
            if (p) chk($sformatf("alt%0d_rd1", g), bus.rdata1, 32'h5A5A0031);
            else   chk($sformatf("alt%0d_rd0", g), bus.rdata0, 32'hA5A50030);
        end
        idle_reqs();
        chk("alt_cnt0", bus.cnt0, 2);
        chk("alt_cnt1", bus.cnt1, 2);

        // Reset during the WAIT cycle of a port-0 read.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        step();
        chk("mid_gnt0", bus.gnt0, 1);
        idle_reqs();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_cs",     bus.mem_cs,    0);
        chk("mid_addr",   bus.mem_addr,  0);
        chk("mid_rv0",    bus.rvalid0,   0);
        chk("mid_rdata0", bus.rdata0,    0);
        chk("mid_rdata1", bus.rdata1,    0);
        chk("mid_cnt0",   bus.cnt0,      0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rv0_a", bus.rvalid0, 0);
        step();
        chk("post_rv0_b", bus.rvalid0, 0);

        // First tie after reset goes to port 0.
        bus.req0 = 1'b1; bus.addr0 = 8'h10;
        bus.req1 = 1'b1; bus.addr1 = 8'h31;
        step();
        chk("tie_gnt0", bus.gnt0, 1);
        chk("tie_gnt1", bus.gnt1, 0);
        idle_reqs();
        step();
        step();
        chk("tie_rv0",  bus.rvalid0, 1);
        chk("tie_rd0",  bus.rdata0,  32'hDEADBEEF);
        chk("tie_cnt0", bus.cnt0,    1);
        chk("tie_cnt1", bus.cnt1,    0);

        // Drive port 1 well past counter saturation.
        for (int i = 0; i < 20; i++) begin
            bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h40; bus.wdata1 = 32'(i);
            step();
            idle_reqs();
            step();
        end
        chk("sat_cnt1", bus.cnt1, 32'hF);
        chk("sat_cnt0", bus.cnt0, 1);

        // Clear in the same cycle the grant is decided wins over the increment.
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h41; bus.wdata1 = 32'h0;
        bus.clr_cnt = 1'b1;
        step();
        bus.clr_cnt = 1'b0;
        chk("clrg_gnt1", bus.gnt1, 1);
        chk("clrg_cnt1", bus.cnt1, 0);
        chk("clrg_cnt0", bus.cnt0, 0);
        idle_reqs();
        step();
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h41;
        step();
        idle_reqs();
        chk("restart_cnt1", bus.cnt1, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
